// File: rtl/williams_pkg.sv
// Shared types for the Williams bus arbiter slice.
// WILLIAMS_ARB_RMW_EN adds the read-modify-write memory states.
package williams_pkg;

  typedef enum logic [1:0] {H_RUN, H_REQ, H_HALTED, H_REL} halt_state_e;

`ifdef WILLIAMS_ARB_RMW_EN
  typedef enum logic [2:0] {M_IDLE, M_ACCESS, M_BLT_HOLD, M_RMW_RD, M_RMW_WR} mem_state_e;
`else
  typedef enum logic [1:0] {M_IDLE, M_ACCESS, M_BLT_HOLD} mem_state_e;
`endif

  typedef enum logic [1:0] {REQ_VID, REQ_BLT, REQ_CPU} req_id_e;

  localparam logic [1:0] NIB_ALL = 2'b11;

  function automatic logic is_partial(input logic [1:0] nib);
    return (nib == 2'b01) || (nib == 2'b10);
  endfunction

endpackage

// File: rtl/williams_arb_rmw.sv
// Nibble merge register for blitter partial writes on memories without nibble enables.
// Only present when WILLIAMS_ARB_RMW_EN is defined.
`ifdef WILLIAMS_ARB_RMW_EN
module williams_arb_rmw
  import williams_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       capture_i,
  input  logic [7:0] rd_data_i,
  input  logic [7:0] wdata_i,
  input  logic [1:0] nib_en_i,
  output logic       wr_ready_o,
  output logic [7:0] merged_o
);

  logic [7:0] merged_q, merged_d;
  logic       ready_q, ready_d;

  always_comb begin
    merged_d = merged_q;
    ready_d  = ready_q;
    if (clear_i) begin
      ready_d = 1'b0;
    end else if (capture_i) begin
      // Enabled nibbles come from the blitter, the rest from the read-back byte.
      merged_d = {nib_en_i[1] ? wdata_i[7:4] : rd_data_i[7:4],
                  nib_en_i[0] ? wdata_i[3:0] : rd_data_i[3:0]};
      ready_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      merged_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      merged_q <= merged_d;
      ready_q  <= ready_d;
    end
  end

  assign wr_ready_o = ready_q;
  assign merged_o   = merged_q;

endmodule
`endif

// File: rtl/williams_bus_arbiter.sv
// Shares the video/work RAM port among video, blitter and 6809 CPU, and owns the CPU HALT handshake.
// Define WILLIAMS_ARB_RMW_EN for memories without nibble enables (partial writes become read-merge-write).
module williams_bus_arbiter
  import williams_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e_en,
  output logic              cpu_halt_n,
  input  logic              cpu_ba,
  input  logic              cpu_bs,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              blt_halt,
  output logic              blt_halt_ack,
  input  logic              blt_rd,
  input  logic              blt_wr,
  input  logic [ADDR_W-1:0] blt_addr,
  input  logic [7:0]        blt_wdata,
  input  logic [1:0]        blt_nibble_en,
  output logic [7:0]        blt_rdata,
  output logic              blt_ack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_rdata,
  output logic              vid_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [1:0]        mem_nib_we,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  halt_state_e       halt_q, halt_d;
  mem_state_e        mem_q, mem_d;
  req_id_e           owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        nib_q, nib_d;
  logic              req_q, req_d;
  logic [3:0]        starve_q, starve_d;
  logic              blt_arm_q, blt_arm_d;
  logic              ign_ack_q;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d, vid_rdata_q, vid_rdata_d, blt_rdata_q, blt_rdata_d;
  logic              cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d;

  logic ack_v, blt_busy, blt_wr_eff, blt_pend, grant_vid, grant_blt, grant_cpu;

`ifdef WILLIAMS_ARB_RMW_EN
  logic       rmw_ready;
  logic [7:0] rmw_merged;

  williams_arb_rmw u_rmw (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (mem_q == M_IDLE),
    .capture_i  ((mem_q == M_RMW_RD) && ack_v),
    .rd_data_i  (mem_rdata),
    .wdata_i    (wdata_q),
    .nib_en_i   (nib_q),
    .wr_ready_o (rmw_ready),
    .merged_o   (rmw_merged)
  );
`endif

  // A mem_ack straggling in from before reset must not complete anything.
  assign ack_v      = mem_ack && req_q && !ign_ack_q;
  assign blt_busy   = (mem_q != M_IDLE) && (owner_q == REQ_BLT);
  assign blt_wr_eff = blt_wr && !blt_rd;
  assign blt_pend   = (blt_rd || blt_wr) && blt_arm_q && (halt_q == H_HALTED);
  assign grant_vid  = vid_req && !(blt_pend && (starve_q >= STARVE_LIM));
  assign grant_blt  = !grant_vid && blt_pend;
  assign grant_cpu  = !vid_req && !blt_pend && cpu_req && (halt_q == H_RUN);

  // ---------------- Halt FSM ----------------
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) halt_q <= H_RUN;
    else     halt_q <= halt_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    halt_d = halt_q;
    case (halt_q)
      H_RUN:    if (blt_halt) halt_d = H_REQ;
      H_REQ:    if (e_en && cpu_ba && cpu_bs) halt_d = H_HALTED;
      H_HALTED: if (!blt_halt && !blt_busy) halt_d = H_REL;
      H_REL:    if (!cpu_ba) halt_d = H_RUN;
      default:  halt_d = H_RUN;
    endcase
  end

  // ---------------- Memory FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q       <= M_IDLE;
      owner_q     <= REQ_VID;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      nib_q       <= 2'b00;
      req_q       <= 1'b0;
      starve_q    <= '0;
      blt_arm_q   <= 1'b1;
      ign_ack_q   <= 1'b1;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      blt_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      nib_q       <= nib_d;
      req_q       <= req_d;
      starve_q    <= starve_d;
      blt_arm_q   <= blt_arm_d;
      ign_ack_q   <= 1'b0;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      blt_rdata_q <= blt_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
    end
  end

  always_comb begin
    mem_d       = mem_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    nib_d       = nib_q;
    req_d       = req_q;
    starve_d    = starve_q;
    blt_arm_d   = blt_arm_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    blt_rdata_d = blt_rdata_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    case (mem_q)
      M_IDLE: begin
        // A blitter beat re-arms only after blt_ack has been low for a cycle.
        blt_arm_d = 1'b1;
        if (grant_vid) begin
          owner_d = REQ_VID;
          addr_d  = vid_addr;
          we_d    = 1'b0;
          req_d   = 1'b1;
          mem_d   = M_ACCESS;
          if (blt_pend && starve_q != 4'hF) starve_d = starve_q + 4'd1;
        end else if (grant_blt) begin
          owner_d   = REQ_BLT;
          addr_d    = blt_addr;
          wdata_d   = blt_wdata;
          we_d      = blt_wr_eff;
          nib_d     = blt_nibble_en;
          starve_d  = '0;
          blt_arm_d = 1'b0;
          if (blt_wr_eff && blt_nibble_en == 2'b00) begin
            mem_d = M_BLT_HOLD;
`ifdef WILLIAMS_ARB_RMW_EN
          end else if (blt_wr_eff && is_partial(blt_nibble_en)) begin
            mem_d = M_RMW_RD;
            req_d = 1'b1;
`endif
          end else begin
            mem_d = M_ACCESS;
            req_d = 1'b1;
          end
        end else if (grant_cpu) begin
          owner_d = REQ_CPU;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          we_d    = cpu_we;
          nib_d   = NIB_ALL;
          req_d   = 1'b1;
          mem_d   = M_ACCESS;
        end
      end
      M_ACCESS: begin
        if (ack_v) begin
          req_d = 1'b0;
          mem_d = M_IDLE;
          case (owner_q)
            REQ_VID: begin
              vid_ack_d   = 1'b1;
              vid_rdata_d = mem_rdata;
            end
            REQ_CPU: begin
              cpu_ack_d = 1'b1;
              if (!we_q) cpu_rdata_d = mem_rdata;
            end
            default: begin
              if (!we_q) blt_rdata_d = mem_rdata;
              mem_d = M_BLT_HOLD;
            end
          endcase
        end
      end
      M_BLT_HOLD: if (e_en) mem_d = M_IDLE;
`ifdef WILLIAMS_ARB_RMW_EN
      M_RMW_RD: begin
        if (ack_v) begin
          req_d = 1'b0;
          mem_d = M_RMW_WR;
        end
      end
      M_RMW_WR: begin
        if (!req_q && rmw_ready) begin
          req_d = 1'b1;
        end else if (ack_v) begin
          req_d = 1'b0;
          mem_d = M_BLT_HOLD;
        end
      end
`endif
      default: mem_d = M_IDLE;
    endcase
  end

  // ---------------- Outputs ----------------
  always_comb begin
    cpu_halt_n   = !((halt_q == H_REQ) || (halt_q == H_HALTED));
    blt_halt_ack = (halt_q == H_HALTED);
    blt_ack      = (mem_q == M_BLT_HOLD);
    mem_req      = req_q;
    mem_addr     = addr_q;
`ifdef WILLIAMS_ARB_RMW_EN
    mem_we       = req_q && (((mem_q == M_ACCESS) && we_q) || (mem_q == M_RMW_WR));
    mem_wdata    = (mem_q == M_RMW_WR) ? rmw_merged : wdata_q;
    mem_nib_we   = NIB_ALL;
`else
    mem_we       = req_q && we_q;
    mem_wdata    = wdata_q;
    mem_nib_we   = (req_q && we_q) ? nib_q : 2'b00;
`endif
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign vid_rdata = vid_rdata_q;
  assign vid_ack   = vid_ack_q;
  assign blt_rdata = blt_rdata_q;

endmodule
